// File: rtl/avalon_dp_ram_if.sv
// Avalon-MM slave bundle for one port of avalon_dp_ram: command inputs and pipelined read response.
// The master modport is the bus-master view; the RAM ports use the slave modport.
interface avalon_dp_ram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  logic                    parity_err;

  modport master (
    output address, byteenable, chipselect, read, write, writedata,
    input  readdata, readdatavalid, parity_err
  );

  modport slave (
    input  address, byteenable, chipselect, read, write, writedata,
    output readdata, readdatavalid, parity_err
  );
endinterface

// File: rtl/avalon_dp_ram.sv
// True dual-port Avalon-MM RAM, two slaves on one array, pipelined reads with readdatavalid.
// Define AVALON_DP_RAM_PARITY_EN to store one even-parity bit per byte and flag mismatches on read.
module avalon_dp_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024,
  parameter int OUT_REG    = 0,
  parameter     INIT_FILE  = "avalon_dp_ram.hex"
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clken,
  avalon_dp_ram_if.slave s1,
  avalon_dp_ram_if.slave s2
);
  localparam int NB = DATA_WIDTH / 8;
`ifdef AVALON_DP_RAM_PARITY_EN
  localparam int WORD_W = DATA_WIDTH + NB;
`else
  localparam int WORD_W = DATA_WIDTH;
`endif

  logic [ADDR_WIDTH-1:0] addr      [2];
  logic [NB-1:0]         be        [2];
  logic [DATA_WIDTH-1:0] wdata     [2];
  logic                  cs        [2];
  logic                  rd        [2];
  logic                  wr        [2];
  logic                  in_range  [2];
  logic                  wr_en     [2];
  logic                  rd_acc    [2];
  logic [DATA_WIDTH-1:0] rdata_o   [2];
  logic                  rvalid_o  [2];
  logic                  perr_o    [2];
`ifdef AVALON_DP_RAM_PARITY_EN
  logic [NB-1:0]         wpar      [2];
`endif

  assign addr[0]  = s1.address;
  assign addr[1]  = s2.address;
  assign be[0]    = s1.byteenable;
  assign be[1]    = s2.byteenable;
  assign wdata[0] = s1.writedata;
  assign wdata[1] = s2.writedata;
  assign cs[0]    = s1.chipselect;
  assign cs[1]    = s2.chipselect;
  assign rd[0]    = s1.read;
  assign rd[1]    = s2.read;
  assign wr[0]    = s1.write;
  assign wr[1]    = s2.write;

  assign s1.readdata      = rdata_o[0];
  assign s2.readdata      = rdata_o[1];
  assign s1.readdatavalid = rvalid_o[0];
  assign s2.readdatavalid = rvalid_o[1];
  assign s1.parity_err    = perr_o[0];
  assign s2.parity_err    = perr_o[1];

  // Contents come from INIT_FILE through the device configuration image; reset never touches them.
  logic [WORD_W-1:0] ram_q [DEPTH];

  // s2 lanes are written first so that s1 overrides any lane both ports enable.
  always_ff @(posedge clk) begin
    for (int p = 1; p >= 0; p--) begin
      if (wr_en[p]) begin
        for (int b = 0; b < NB; b++) begin
          if (be[p][b]) begin
            ram_q[addr[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
`ifdef AVALON_DP_RAM_PARITY_EN
            ram_q[addr[p]][DATA_WIDTH+b] <= wpar[p][b];
`endif
          end
        end
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic              acc;
    logic [WORD_W-1:0] rd_raw_q;
    logic              v1_q, v1_d;
    logic              zero1_q, zero1_d;
    logic              perr_raw;
    logic [DATA_WIDTH-1:0] data1;
    logic              perr1;

    assign in_range[gi] = {1'b0, addr[gi]} < (ADDR_WIDTH+1)'(DEPTH);
    assign acc          = clken & ~reset & cs[gi];
    assign wr_en[gi]    = acc & wr[gi] & in_range[gi];
    assign rd_acc[gi]   = acc & rd[gi] & ~wr[gi];

`ifdef AVALON_DP_RAM_PARITY_EN
    logic [NB-1:0] rpar;
    for (genvar li = 0; li < NB; li++) begin : g_lane
      assign wpar[gi][li] = ^wdata[gi][li*8 +: 8];
      assign rpar[li]     = ^rd_raw_q[li*8 +: 8];
    end
    assign perr_raw = |(rpar ^ rd_raw_q[WORD_W-1:DATA_WIDTH]);
`else
    assign perr_raw = 1'b0;
`endif

    // Plain registered array read; out-of-range words are masked by zero1_q downstream.
    always_ff @(posedge clk) begin
      if (rd_acc[gi]) begin
        rd_raw_q <= ram_q[addr[gi]];
      end
    end

    always_comb begin
      v1_d    = v1_q;
      zero1_d = zero1_q;
      if (reset) begin
        v1_d    = 1'b0;
        zero1_d = 1'b1;
      end else if (clken) begin
        v1_d = rd_acc[gi];
        if (rd_acc[gi]) begin
          zero1_d = ~in_range[gi];
        end
      end
    end

    always_ff @(posedge clk) begin
      v1_q    <= v1_d;
      zero1_q <= zero1_d;
    end

    assign data1 = zero1_q ? '0 : rd_raw_q[DATA_WIDTH-1:0];
    assign perr1 = v1_q & ~zero1_q & perr_raw;

    if (OUT_REG != 0) begin : g_out_reg
      logic                  v2_q, v2_d;
      logic [DATA_WIDTH-1:0] rdata2_q, rdata2_d;
      logic                  perr2_q, perr2_d;

      always_comb begin
        v2_d     = v2_q;
        rdata2_d = rdata2_q;
        perr2_d  = perr2_q;
        if (reset) begin
          v2_d     = 1'b0;
          rdata2_d = '0;
          perr2_d  = 1'b0;
        end else if (clken) begin
          v2_d    = v1_q;
          perr2_d = perr1;
          if (v1_q) begin
            rdata2_d = data1;
          end
        end
      end

      always_ff @(posedge clk) begin
        v2_q     <= v2_d;
        rdata2_q <= rdata2_d;
        perr2_q  <= perr2_d;
      end

      assign rvalid_o[gi] = v2_q;
      assign rdata_o[gi]  = rdata2_q;
      assign perr_o[gi]   = perr2_q;
    end else begin : g_no_out_reg
      assign rvalid_o[gi] = v1_q;
      assign rdata_o[gi]  = data1;
      assign perr_o[gi]   = perr1;
    end
  end
endmodule

// File: tb/tb_avalon_dp_ram.sv
// Scoreboard bench for avalon_dp_ram: stimulus pushes expected reads, a negedge monitor pops and compares.
module tb_avalon_dp_ram;
  localparam int OUT_REG = 1;
  localparam int DEPTH   = 1000;

  typedef struct {
    logic [31:0] data;
    logic        perr;
    int          due;
  } exp_t;

  logic clk;
  logic reset;
  logic clken;
  int   cyc    = 0;
  int   checks = 0;
  int   passes = 0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  logic [31:0] sv [8];

  avalon_dp_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) s1_if ();
  avalon_dp_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) s2_if ();

  avalon_dp_ram #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(10),
    .DEPTH     (DEPTH),
    .OUT_REG   (OUT_REG),
    .INIT_FILE ("avalon_dp_ram.hex")
  ) dut (
    .clk  (clk),
    .reset(reset),
    .clken(clken),
    .s1   (s1_if),
    .s2   (s2_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (s1_if.readdatavalid === 1'b1) begin
      if (q1.size() == 0) begin
        checks++;
        $display("FAIL s1_unexpected_valid: got valid with data %h, expected no valid", s1_if.readdata);
      end else begin
        e1 = q1.pop_front();
        $display("s1 read response data=%h perr=%0b cycle=%0d", s1_if.readdata, s1_if.parity_err, cyc);
        chk("s1_data", s1_if.readdata, e1.data);
        chk("s1_perr", {31'b0, s1_if.parity_err}, {31'b0, e1.perr});
        chk("s1_latency", cyc, e1.due);
      end
    end
    if (s2_if.readdatavalid === 1'b1) begin
      if (q2.size() == 0) begin
        checks++;
        $display("FAIL s2_unexpected_valid: got valid with data %h, expected no valid", s2_if.readdata);
      end else begin
        e2 = q2.pop_front();
        $display("s2 read response data=%h perr=%0b cycle=%0d", s2_if.readdata, s2_if.parity_err, cyc);
        chk("s2_data", s2_if.readdata, e2.data);
        chk("s2_perr", {31'b0, s2_if.parity_err}, {31'b0, e2.perr});
        chk("s2_latency", cyc, e2.due);
      end
    end
  end

  task automatic clr();
    s1_if.chipselect = 1'b0; s1_if.read = 1'b0; s1_if.write = 1'b0;
    s1_if.address = '0; s1_if.byteenable = '0; s1_if.writedata = '0;
    s2_if.chipselect = 1'b0; s2_if.read = 1'b0; s2_if.write = 1'b0;
    s2_if.address = '0; s2_if.byteenable = '0; s2_if.writedata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input int p, input int a, input logic [31:0] d, input logic [3:0] be);
    $display("s%0d write addr=%0d data=%h be=%h", p, a, d, be);
    if (p == 1) begin
      s1_if.chipselect = 1'b1; s1_if.write = 1'b1; s1_if.address = 10'(a);
      s1_if.byteenable = be; s1_if.writedata = d;
    end else begin
      s2_if.chipselect = 1'b1; s2_if.write = 1'b1; s2_if.address = 10'(a);
      s2_if.byteenable = be; s2_if.writedata = d;
    end
  endtask

  task automatic rd(input int p, input int a, input logic [31:0] d, input logic pe, input bit expect_valid);
    exp_t e;
    e.data = d;
    e.perr = pe;
    e.due  = cyc + 1 + OUT_REG;
    $display("s%0d read addr=%0d expect=%h", p, a, d);
    if (p == 1) begin
      s1_if.chipselect = 1'b1; s1_if.read = 1'b1; s1_if.address = 10'(a);
      if (expect_valid) q1.push_back(e);
    end else begin
      s2_if.chipselect = 1'b1; s2_if.read = 1'b1; s2_if.address = 10'(a);
      if (expect_valid) q2.push_back(e);
    end
  endtask

  initial begin
    sv[0] = 32'h0000_1000; sv[1] = 32'h1111_2001; sv[2] = 32'h2222_3002; sv[3] = 32'h3333_4003;
    sv[4] = 32'h4444_5004; sv[5] = 32'h5555_6005; sv[6] = 32'h6666_7006; sv[7] = 32'h7777_8007;
    clr();
    reset = 1'b1;
    clken = 1'b1;
    idle(3);
    @(negedge clk);
    chk("reset_s1_valid", {31'b0, s1_if.readdatavalid}, 32'd0);
    chk("reset_s1_data", s1_if.readdata, 32'd0);
    chk("reset_s2_perr", {31'b0, s2_if.parity_err}, 32'd0);
    reset = 1'b0;
    step();
    @(negedge clk);
    chk("post_reset_s1_data", s1_if.readdata, 32'd0);
    chk("post_reset_s2_valid", {31'b0, s2_if.readdatavalid}, 32'd0);

    // basic write on s1, read on s2
    wr(1, 5, 32'hDEAD_BEEF, 4'hF); step();
    rd(2, 5, 32'hDEAD_BEEF, 1'b0, 1'b1); step();

    // byte lanes and dual-write collision
    wr(1, 16, 32'h0000_0000, 4'hF); step();
    wr(1, 16, 32'h1111_1111, 4'h3); wr(2, 16, 32'h2222_2222, 4'h6); step();
    rd(1, 16, 32'h0022_1111, 1'b0, 1'b1); step();

    // mixed-port same cycle: read sees old data
    wr(1, 32, 32'hAAAA_5555, 4'hF); step();
    wr(1, 32, 32'h1234_5678, 4'hF); rd(2, 32, 32'hAAAA_5555, 1'b0, 1'b1); step();
    rd(2, 32, 32'h1234_5678, 1'b0, 1'b1); step();

    // same-port read right after write, and read+write on one port (read dropped)
    wr(1, 33, 32'h0BAD_F00D, 4'hF); step();
    rd(1, 33, 32'h0BAD_F00D, 1'b0, 1'b1); step();
    wr(1, 34, 32'h5A5A_5A5A, 4'hF); rd(1, 34, 32'h0, 1'b0, 1'b0); step();
    rd(1, 34, 32'h5A5A_5A5A, 1'b0, 1'b1); step();

    // streaming
    for (int i = 0; i < 8; i += 2) begin
      wr(1, i, sv[i], 4'hF); wr(2, i + 1, sv[i+1], 4'hF); step();
    end
    wr(2, 10, 32'h0000_000A, 4'hF); step();
    for (int i = 0; i < 8; i++) begin
      rd(1, i, sv[i], 1'b0, 1'b1); step();
    end
    idle(3);

    // reset one cycle after the third read flushes it; a read with reset is not accepted
    rd(1, 0, sv[0], 1'b0, 1'b1); step();
    rd(1, 1, sv[1], 1'b0, 1'b1); step();
    rd(1, 2, sv[2], 1'b0, 1'b0); step();
    reset = 1'b1; rd(1, 3, sv[3], 1'b0, 1'b0); step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_stream_valid", {31'b0, s1_if.readdatavalid}, 32'd0);
    chk("rst_stream_data", s1_if.readdata, 32'd0);
    step();
    @(negedge clk);
    chk("rst_stream_after_data", s1_if.readdata, 32'd0);
    idle(3);
    rd(1, 2, sv[2], 1'b0, 1'b1); step();

    // out of range and the last in-range word
    wr(1, 1010, 32'hFFFF_FFFF, 4'hF); wr(2, 999, 32'h9999_9999, 4'hF); step();
    rd(1, 1010, 32'h0, 1'b0, 1'b1); rd(2, 999, 32'h9999_9999, 1'b0, 1'b1); step();
    rd(1, 10, 32'h0000_000A, 1'b0, 1'b1); rd(2, 1023, 32'h0, 1'b0, 1'b1); step();
    rd(1, 999, 32'h9999_9999, 1'b0, 1'b1); step();
    idle(3);

    // clken low: read lost, outputs hold
    clken = 1'b0;
    rd(1, 0, sv[0], 1'b0, 1'b0); step();
    @(negedge clk);
    chk("clken_hold_data", s1_if.readdata, 32'h9999_9999);
    chk("clken_no_valid", {31'b0, s1_if.readdatavalid}, 32'd0);
    clken = 1'b1;
    idle(3);

`ifdef AVALON_DP_RAM_PARITY_EN
    wr(1, 48, 32'h0F0F_0F0F, 4'hF); step();
    dut.ram_q[48][16] = ~dut.ram_q[48][16];
    rd(1, 48, 32'h0F0E_0F0F, 1'b1, 1'b1); step();
    idle(2);
    wr(1, 48, 32'h0F0F_0F0F, 4'hF); step();
    rd(1, 48, 32'h0F0F_0F0F, 1'b0, 1'b1); step();
    idle(2);
`endif

    idle(4);
    chk("s1_queue_drained", q1.size(), 32'd0);
    chk("s2_queue_drained", q2.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/avalon_dp_ram.md
# avalon_dp_ram

Parametrised true dual-port on-chip RAM with two independent Avalon-MM slaves (s1, s2) sharing one memory array. It is the next-generation replacement for the single-port 1024×32 Qsys RAM. It adds configurable width and depth, a second port, a pipelined read path with `readdatavalid`, deterministic collision rules, and optional per-byte parity. It sits on the HPS/FPGA fabric interconnect as a shared scratch/mailbox memory between two masters.

## Interface
Parameters:
- `DATA_WIDTH`, 32: word width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 10: word-address width.
- `DEPTH`, 1024: number of words; must satisfy DEPTH ≤ 2^ADDR_WIDTH.
- `OUT_REG`, 0: 0 gives read latency 1; 1 adds an output register for read latency 2.
- `INIT_FILE`, "avalon_dp_ram.hex": memory initialisation file, loaded at configuration only.

Ports (x ∈ {1,2}, every per-port signal exists for both s1 and s2):
- `clk` in 1: single clock for both ports.
- `reset` in 1: synchronous, active-high.
- `clken` in 1: global clock enable; low freezes all state.
- `sx_address` in ADDR_WIDTH: word address.
- `sx_byteenable` in DATA_WIDTH/8: write byte lanes.
- `sx_chipselect` in 1: port select.
- `sx_read` in 1: read command.
- `sx_write` in 1: write command.
- `sx_writedata` in DATA_WIDTH: write data.
- `sx_readdata` out DATA_WIDTH: read data.
- `sx_readdatavalid` out 1: `sx_readdata` is valid this cycle.
- `sx_parity_err` out 1: parity mismatch on the current valid read word.

## Operation
- No waitrequest. A command is accepted on any rising edge where `clken`=1, `reset`=0 and `sx_chipselect`=1.
- **Write:** requires `sx_write`=1. Only lanes with `byteenable` set are updated.
- **Read:** requires `sx_read`=1 and `sx_write`=0. Each accepted read produces exactly one `readdatavalid` pulse, in issue order. Each port runs a fixed-depth shift pipeline of valid bits, depth 1+OUT_REG.
- **Read and write on the same port in the same cycle:** the write is performed, the read is dropped, and no `readdatavalid` is produced.
- **Same-port read-during-write** (consecutive cycles to the same address): the read returns the newly written data.
- **Mixed-port, same cycle, same address** (one port reads, the other writes): the read returns the old data.
- **Dual write, same cycle, same address:** per byte lane, s1 wins where both ports enable the lane. Lanes enabled only by s2 take s2 data.
- **Address ≥ DEPTH:** the write is discarded. The read is still acknowledged, with `readdata`=0 and `parity_err`=0.
- **`clken`=0:** nothing is accepted, and the pipeline and outputs hold. Commands presented in this state are lost; masters must not issue them.
- **Reset:** flushes the read pipelines, so in-flight reads are discarded and never signalled. Memory contents are preserved.
- **Outputs during and after reset:** `readdatavalid`=0, `readdata`=0 and `parity_err`=0 during reset and in the first cycle after it.
- **`readdata` when not valid:** held at the last valid value.

## Timing
- Read accepted at edge N gives `readdatavalid`=1 and data in the cycle following edge N+OUT_REG.
- Latency is 1 cycle when OUT_REG=0 and 2 cycles when OUT_REG=1, with `clken` high throughout.
- Throughput is one read or one write per port per cycle. Back-to-back reads give back-to-back valid pulses.
- A write at edge N is visible to a read on either port accepted at edge N+1 or later.
- `reset` asserted on the same edge as a read command takes precedence: the read is not accepted.

## Configuration
- Macro `AVALON_DP_RAM_PARITY_EN`.
- **Defined:**
  - Each byte is stored with one even-parity bit, so the array width is DATA_WIDTH+DATA_WIDTH/8.
  - Parity is generated from write data per lane.
  - Parity is checked per lane on read.
  - `sx_parity_err`=1 together with `readdatavalid` if any lane mismatches.
  - Data is returned unmodified, with no correction.
- **Not defined:**
  - The array width is DATA_WIDTH.
  - `sx_parity_err` is tied to constant 0.
  - All other behaviour is identical.

## Test plan
- **Basic write/read:** s1 writes 0xDEADBEEF to address 0x005 with byteenable 0xF, then s2 reads 0x005. s2 gets `readdatavalid` after 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1) with data 0xDEADBEEF.
- **Byte lanes and dual-write collision:** preload 0x00000000 at address 0x010. In the same cycle, s1 writes 0x11111111 with byteenable 0x3 and s2 writes 0x22222222 with byteenable 0x6. A subsequent read returns 0x00221111.
- **Mixed-port same cycle:** address 0x020 holds 0xAAAA5555. s1 writes 0x12345678 while s2 reads 0x020. s2 gets 0xAAAA5555; the next s2 read gets 0x12345678.
- **Streaming:** eight back-to-back s1 reads of addresses 0..7 produce eight consecutive `readdatavalid` pulses with data in address order. `reset` pulsed one cycle after the third read yields no further valid pulses and `readdata`=0.
- **Out-of-range and clken:** with DEPTH=1000, a write to address 1010 leaves memory unchanged and a read of 1010 returns 0 with valid. A read issued with `clken`=0 produces no valid pulse.
- **Parity (macro defined):** force a bit flip in byte 2 of the stored word at address 0x030. A read returns valid with `s1_parity_err`=1. Rewriting the word clears the error on the next read.
